regfile_88: RTL and testbench

- Bank of eight 8-bit registers (r0..r7) whose outputs drive the eight data inputs (a..h) of the downstream 8:1 byte mux.
- Provides one byte write port and one single-cycle register-to-register move port.
- r6:r7 also act as a 16-bit pointer with increment/decrement (r6 = high byte, r7 = low byte).
- Sits between the datapath write-back bus and the source-select mux.

---
 rtl/regfile_88.sv | 100 ++++++++++
 tb/tb_regfile_88.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_88.sv
// Eight-register byte bank feeding the 8:1 source mux, with a write port, a
// register-to-register move port and a 16-bit pointer formed by {r6,r7}.
module regfile_88 #(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mv_en,
  input  logic [2:0]       mv_src,
  input  logic [2:0]       mv_dst,
  input  logic             ptr_inc,
  input  logic             ptr_dec,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             ptr_wrap,
  output logic             op_err
);

  localparam logic [2*WIDTH-1:0] PTR_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] PTR_MAX = '1;

  logic [WIDTH-1:0]   r_regs [8];
  logic               r_ptr_wrap;
  logic               r_op_err;

  logic [WIDTH-1:0]   w_next [8];
  logic [2*WIDTH-1:0] w_ptr;
  logic               w_tgt_ptr;
  logic               w_mv_clash;
  logic               w_wrap;
  logic               w_err;

  assign w_ptr     = {r_regs[6], r_regs[7]};
  assign w_tgt_ptr = (wr_en && (wr_sel[2:1] == 2'b11)) ||
                     (mv_en && (mv_dst[2:1] == 2'b11));
  // A self-move is a no-op, so it never collides with a write.
  assign w_mv_clash = mv_en && wr_en && (wr_sel == mv_dst) && (mv_src != mv_dst);

  always_comb begin
    w_next = r_regs;
    w_wrap = 1'b0;
    w_err  = w_mv_clash;

    if (ptr_inc && ptr_dec) begin
      w_err = 1'b1;
    end else if ((ptr_inc || ptr_dec) && w_tgt_ptr) begin
      w_err = 1'b1;
    end else if (ptr_inc) begin
      {w_next[6], w_next[7]} = w_ptr + PTR_ONE;
      w_wrap = (w_ptr == PTR_MAX);
    end else if (ptr_dec) begin
      {w_next[6], w_next[7]} = w_ptr - PTR_ONE;
      w_wrap = (w_ptr == '0);
    end

    // Move reads pre-edge values; the write is applied last so it wins.
    if (mv_en && !w_mv_clash) begin
      w_next[mv_dst] = r_regs[mv_src];
    end
    if (wr_en) begin
      w_next[wr_sel] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_ptr_wrap <= 1'b0;
      r_op_err   <= 1'b0;
    end else begin
      r_regs     <= w_next;
      r_ptr_wrap <= w_wrap;
      r_op_err   <= w_err;
    end
  end

  assign a        = r_regs[0];
  assign b        = r_regs[1];
  assign c        = r_regs[2];
  assign d        = r_regs[3];
  assign e        = r_regs[4];
  assign f        = r_regs[5];
  assign g        = r_regs[6];
  assign h        = r_regs[7];
  assign ptr_wrap = r_ptr_wrap;
  assign op_err   = r_op_err;

endmodule

// File: tb/tb_regfile_88.sv
// Directed table-driven bench for regfile_88: each row is one clock of
// stimulus with the full register image and pulse flags expected after it.
module tb_regfile_88;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic       mv_en;
  logic [2:0] mv_src;
  logic [2:0] mv_dst;
  logic       ptr_inc;
  logic       ptr_dec;
  logic [7:0] a, b, c, d, e, f, g, h;
  logic       ptr_wrap;
  logic       op_err;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_88 #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .mv_en(mv_en), .mv_src(mv_src), .mv_dst(mv_dst),
    .ptr_inc(ptr_inc), .ptr_dec(ptr_dec),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .ptr_wrap(ptr_wrap), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        mv_en;
    logic [2:0]  mv_src;
    logic [2:0]  mv_dst;
    logic        inc;
    logic        dec;
    logic [63:0] exp_regs;  // {a,b,c,d,e,f,g,h}
    logic        exp_wrap;
    logic        exp_err;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [2:0] ws, input logic [7:0] wd,
                              input logic me, input logic [2:0] ms, input logic [2:0] md,
                              input logic pi, input logic pd,
                              input logic [63:0] er, input logic ew, input logic ee);
    vec_t v;
    v.wr_en = we; v.wr_sel = ws; v.wr_data = wd;
    v.mv_en = me; v.mv_src = ms; v.mv_dst = md;
    v.inc = pi; v.dec = pd;
    v.exp_regs = er; v.exp_wrap = ew; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_sel = 3'd0; wr_data = 8'h00;
    mv_en = 1'b0; mv_src = 3'd0; mv_dst = 3'd0;
    ptr_inc = 1'b0; ptr_dec = 1'b0;
  endtask

  initial begin
    //            we ws    wd     me ms    md    inc dec  expected a..h               wrap err
    vecs[0]  = mk(1, 3'd0, 8'h11, 0, 3'd0, 3'd0, 0, 0, 64'h11000000_00000000, 0, 0);
    vecs[1]  = mk(1, 3'd1, 8'h22, 0, 3'd0, 3'd0, 0, 0, 64'h11220000_00000000, 0, 0);
    vecs[2]  = mk(1, 3'd2, 8'h33, 0, 3'd0, 3'd0, 0, 0, 64'h11223300_00000000, 0, 0);
    vecs[3]  = mk(1, 3'd3, 8'h44, 0, 3'd0, 3'd0, 0, 0, 64'h11223344_00000000, 0, 0);
    vecs[4]  = mk(1, 3'd4, 8'h55, 0, 3'd0, 3'd0, 0, 0, 64'h11223344_55000000, 0, 0);
    vecs[5]  = mk(1, 3'd5, 8'h66, 0, 3'd0, 3'd0, 0, 0, 64'h11223344_55660000, 0, 0);
    vecs[6]  = mk(1, 3'd6, 8'h77, 0, 3'd0, 3'd0, 0, 0, 64'h11223344_55667700, 0, 0);
    vecs[7]  = mk(1, 3'd7, 8'h88, 0, 3'd0, 3'd0, 0, 0, 64'h11223344_55667788, 0, 0);
    vecs[8]  = mk(0, 3'd0, 8'h00, 1, 3'd2, 3'd5, 0, 0, 64'h11223344_55337788, 0, 0);
    vecs[9]  = mk(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 0, 64'h11223344_55337788, 0, 0);
    vecs[10] = mk(1, 3'd3, 8'hAA, 1, 3'd1, 3'd3, 0, 0, 64'h112233AA_55337788, 0, 1);
    vecs[11] = mk(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 0, 64'h112233AA_55337788, 0, 0);
    vecs[12] = mk(1, 3'd6, 8'hFF, 0, 3'd0, 3'd0, 0, 0, 64'h112233AA_5533FF88, 0, 0);
    vecs[13] = mk(1, 3'd7, 8'hFE, 0, 3'd0, 3'd0, 0, 0, 64'h112233AA_5533FFFE, 0, 0);
    vecs[14] = mk(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 1, 0, 64'h112233AA_5533FFFF, 0, 0);
    vecs[15] = mk(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 1, 0, 64'h112233AA_55330000, 1, 0);
    vecs[16] = mk(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 1, 64'h112233AA_5533FFFF, 1, 0);
    vecs[17] = mk(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 0, 64'h112233AA_5533FFFF, 0, 0);
    vecs[18] = mk(1, 3'd6, 8'h12, 0, 3'd0, 3'd0, 0, 0, 64'h112233AA_553312FF, 0, 0);
    vecs[19] = mk(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 1, 0, 64'h112233AA_55331300, 0, 0);
    vecs[20] = mk(1, 3'd7, 8'h05, 0, 3'd0, 3'd0, 1, 0, 64'h112233AA_55331305, 0, 1);
    vecs[21] = mk(0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 1, 1, 64'h112233AA_55331305, 0, 1);
    vecs[22] = mk(1, 3'd0, 8'h5A, 0, 3'd0, 3'd0, 0, 1, 64'h5A2233AA_55331304, 0, 0);
    vecs[23] = mk(0, 3'd0, 8'h00, 1, 3'd6, 3'd1, 0, 0, 64'h5A1333AA_55331304, 0, 0);
    vecs[24] = mk(1, 3'd2, 8'hC3, 1, 3'd3, 3'd4, 0, 0, 64'h5A13C3AA_AA331304, 0, 0);
    vecs[25] = mk(1, 3'd4, 8'h77, 1, 3'd4, 3'd0, 0, 0, 64'hAA13C3AA_77331304, 0, 0);
    vecs[26] = mk(0, 3'd0, 8'h00, 1, 3'd5, 3'd5, 0, 0, 64'hAA13C3AA_77331304, 0, 0);
    vecs[27] = mk(0, 3'd0, 8'h00, 1, 3'd0, 3'd6, 0, 1, 64'hAA13C3AA_7733AA04, 0, 1);
    vecs[28] = mk(1, 3'd6, 8'hFF, 0, 3'd0, 3'd0, 0, 0, 64'hAA13C3AA_7733FF04, 0, 0);
    vecs[29] = mk(1, 3'd7, 8'hFF, 0, 3'd0, 3'd0, 0, 0, 64'hAA13C3AA_7733FFFF, 0, 0);

    idle();
    reset_n = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_regs", {a, b, c, d, e, f, g, h}, 64'h0);
    check("reset_wrap", {63'h0, ptr_wrap}, 64'h0);
    check("reset_err",  {63'h0, op_err},   64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      wr_en = vecs[i].wr_en; wr_sel = vecs[i].wr_sel; wr_data = vecs[i].wr_data;
      mv_en = vecs[i].mv_en; mv_src = vecs[i].mv_src; mv_dst = vecs[i].mv_dst;
      ptr_inc = vecs[i].inc; ptr_dec = vecs[i].dec;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_regs", i), {a, b, c, d, e, f, g, h}, vecs[i].exp_regs);
      check($sformatf("v%0d_wrap", i), {63'h0, ptr_wrap}, {63'h0, vecs[i].exp_wrap});
      check($sformatf("v%0d_err", i),  {63'h0, op_err},   {63'h0, vecs[i].exp_err});
    end

    // Reset lands during a ptr_inc that would wrap P = 0xFFFF.
    @(negedge clk);
    idle();
    ptr_inc = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_regs", {a, b, c, d, e, f, g, h}, 64'h0);
    @(posedge clk);
    #1;
    check("midrst_hold_regs", {a, b, c, d, e, f, g, h}, 64'h0);
    check("midrst_hold_wrap", {63'h0, ptr_wrap}, 64'h0);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_regs", {a, b, c, d, e, f, g, h}, 64'h0);
    check("postrst_wrap", {63'h0, ptr_wrap}, 64'h0);
    check("postrst_err",  {63'h0, op_err},   64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
